// File: rtl/cmd_status_encoder_if.sv
// UART byte stream in, status display code and event pulses out.
// master = byte source / display side, slave = encoder.
interface cmd_status_encoder_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic [3:0] o_hex;
    logic [2:0] o_cmd;
    logic       o_cmd_strobe;
    logic       o_err;
    logic [7:0] o_err_cnt;
    logic       o_timeout;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_hex, o_cmd, o_cmd_strobe, o_err, o_err_cnt, o_timeout
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_hex, o_cmd, o_cmd_strobe, o_err, o_err_cnt, o_timeout
    );
endinterface

// File: rtl/cmd_status_encoder.sv
// ASCII drive-command decoder with link watchdog and error counter.
// Drives the seven-segment status code: [3] link up, [2:0] command.
module cmd_status_encoder #(
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    cmd_status_encoder_if.slave  bus
);
    typedef enum logic {LINK_DOWN, LINK_UP} state_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [2:0] cmd_q, cmd_d;
    logic       strobe_q, strobe_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       timeout_q, timeout_d;

    logic [7:0] up_byte;
    logic       known;
    logic       is_hb;
    logic [2:0] code;
    logic       rec;

    // Fold lower case onto upper case before the lookup.
    always_comb begin
        up_byte = bus.i_rx_data;
        if (up_byte inside {[8'h61:8'h7a]})
            up_byte = up_byte - 8'h20;
        known = 1'b1;
        is_hb = 1'b0;
        code  = 3'd0;
        case (up_byte)
            8'h54:   code  = 3'd1;
            8'h46:   code  = 3'd2;
            8'h52:   code  = 3'd3;
            8'h42:   code  = 3'd4;
            8'h4c:   code  = 3'd5;
            8'h44:   code  = 3'd6;
            8'h53:   code  = 3'd0;
            8'h48:   is_hb = 1'b1;
            default: known = 1'b0;
        endcase
    end

    assign rec = bus.i_rx_valid && known;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        cmd_d     = cmd_q;
        timeout_d = 1'b0;
        err_d     = bus.i_rx_valid && !known;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hff)
            err_cnt_d = err_cnt_q + 8'd1;

        unique case (state_q)
            LINK_DOWN: begin
                wd_d  = '0;
                cmd_d = 3'd0;
                if (rec) begin
                    state_d = LINK_UP;
                    cmd_d   = is_hb ? 3'd0 : code;
                end
            end
            LINK_UP: begin
                // A recognised byte in the expiry cycle keeps the link up.
                if (rec) begin
                    wd_d = '0;
                    if (!is_hb)
                        cmd_d = code;
                end else if (wd_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = LINK_DOWN;
                    cmd_d     = 3'd0;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            default: state_d = LINK_DOWN;
        endcase

        strobe_d = (cmd_d != cmd_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= LINK_DOWN;
            wd_q      <= '0;
            cmd_q     <= 3'd0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            cmd_q     <= cmd_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_hex        = {state_q == LINK_UP, cmd_q};
    assign bus.o_cmd        = cmd_q;
    assign bus.o_cmd_strobe = strobe_q;
    assign bus.o_err        = err_q;
    assign bus.o_err_cnt    = err_cnt_q;
    assign bus.o_timeout    = timeout_q;
endmodule

// File: tb/tb_cmd_status_encoder.sv
// Scoreboard bench for cmd_status_encoder with TIMEOUT_CYC = 20.
// Driver queues per-cycle expectations; monitor pops and compares.
module tb_cmd_status_encoder;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cmd_status_encoder_if bus ();

    cmd_status_encoder #(.TIMEOUT_CYC(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // {hex, cmd, strobe, err, timeout, err_cnt}
    logic [17:0] q_exp[$];
    string       q_tag[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt_exp = 0;
    string       phase = "init";

    task automatic push(input logic [3:0] hex, input logic stb,
                        input logic err, input logic tmo);
        q_exp.push_back({hex, hex[2:0], stb, err, tmo, 8'(cnt_exp)});
        q_tag.push_back(phase);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic [3:0] hex, input logic stb,
                       input logic err, input logic tmo);
        @(negedge clk);
        rst = 1'b0;
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        if (err && cnt_exp < 255)
            cnt_exp = cnt_exp + 1;
        push(hex, stb, err, tmo);
    endtask

    task automatic rst_cyc(input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = 1'b1;
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        cnt_exp = 0;
        push(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic [3:0] hex);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 8'h00, hex, 1'b0, 1'b0, 1'b0);
    endtask

    // Caller has just had the last recognised byte accepted.
    task automatic expire(input logic [3:0] hex_up);
        idle(TO - 1, hex_up);
        cyc(1'b0, 8'h00, 4'h0, hex_up[2:0] != 3'd0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        logic [17:0] exp;
        logic [17:0] got;
        string       tag;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() != 0) begin
                exp = q_exp.pop_front();
                tag = q_tag.pop_front();
                got = {bus.o_hex, bus.o_cmd, bus.o_cmd_strobe, bus.o_err,
                       bus.o_timeout, bus.o_err_cnt};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s t=%0t: got hex=%b cmd=%0d stb=%b err=%b tmo=%b cnt=%0d, want hex=%b cmd=%0d stb=%b err=%b tmo=%b cnt=%0d",
                             tag, $time,
                             got[17:14], got[13:11], got[10], got[9], got[8], got[7:0],
                             exp[17:14], exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
                end
            end
        end
    end

    initial begin : driver
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;

        phase = "reset";
        rst_cyc(1'b0, 8'h00);
        rst_cyc(1'b0, 8'h00);

        phase = "idle50";
        idle(50, 4'b0000);

        phase = "F_f_L";
        cyc(1'b1, "F", 4'b1010, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "f", 4'b1010, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, "L", 4'b1101, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "l", 4'b1101, 1'b0, 1'b0, 1'b0);

        phase = "R_timeout";
        cyc(1'b1, "R", 4'b1011, 1'b1, 1'b0, 1'b0);
        expire(4'b1011);
        idle(5, 4'b0000);

        phase = "heartbeat";
        cyc(1'b1, "R", 4'b1011, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            idle(14, 4'b1011);
            cyc(1'b1, "H", 4'b1011, 1'b0, 1'b0, 1'b0);
        end
        expire(4'b1011);

        phase = "bad3";
        cyc(1'b1, "T", 4'b1001, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "Q", 4'b1001, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, "7", 4'b1001, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hff, 4'b1001, 1'b0, 1'b1, 1'b0);
        idle(TO - 4, 4'b1001);
        cyc(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b1);

        phase = "bad300";
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 8'(8'h30 + (i % 10)), 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(3, 4'b0000);

        phase = "byte_wins";
        cyc(1'b1, "B", 4'b1100, 1'b1, 1'b0, 1'b0);
        idle(TO - 1, 4'b1100);
        cyc(1'b1, "d", 4'b1110, 1'b1, 1'b0, 1'b0);

        phase = "err_at_expiry";
        idle(TO - 1, 4'b1110);
        cyc(1'b1, "Z", 4'b0000, 1'b1, 1'b1, 1'b1);
        idle(3, 4'b0000);

        phase = "b2b";
        cyc(1'b1, "t", 4'b1001, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "F", 4'b1010, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "r", 4'b1011, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "S", 4'b1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "s", 4'b1000, 1'b0, 1'b0, 1'b0);
        expire(4'b1000);

        phase = "H_from_down";
        cyc(1'b1, "h", 4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, "T", 4'b1001, 1'b1, 1'b0, 1'b0);

        phase = "rst_override";
        rst_cyc(1'b1, "B");
        idle(TO + 5, 4'b0000);

        @(posedge clk);
        #2;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_status_encoder.md
# cmd_status_encoder

Converts the ASCII drive-command byte stream from the UART receiver into the 4-bit status code that drives the seven-segment status display. It holds the current drive command, keeps a link-alive watchdog, and flags unrecognised bytes. It sits between the UART RX byte interface and the seven-segment decoder; its `o_hex` connects directly to the decoder's `i_hex`.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 25_000_000: watchdog length in clock cycles (0.5 s at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(TIMEOUT_CYC+1)`: watchdog counter width. Derived; not overridden.

Ports:
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_rx_valid`, in, 1: one-cycle strobe; `i_rx_data` is valid this cycle.
- `i_rx_data`, in, 8: received ASCII byte.
- `o_hex`, out, 4: display code. `[3]` = link up; `[2:0]` = current command.
- `o_cmd`, out, 3: current command, equal to `o_hex[2:0]`.
- `o_cmd_strobe`, out, 1: one-cycle pulse when `o_cmd` changes value.
- `o_err`, out, 1: one-cycle pulse on an unrecognised byte.
- `o_err_cnt`, out, 8: saturating count of unrecognised bytes.
- `o_timeout`, out, 1: one-cycle pulse when the watchdog drops the link.

## Operation

Byte decode is case-insensitive. Upper and lower case letters are equivalent.
- `T` → 1, `F` → 2, `R` → 3, `B` → 4, `L` → 5, `D` → 6.
- `S` → 0 (stop; link stays up).
- `H` → heartbeat. Refreshes the watchdog; command unchanged.
- Any other byte is unrecognised. It pulses `o_err`, increments `o_err_cnt` (saturating at 255), and leaves state, command and watchdog untouched.
- The command code 7 is never produced.

States: LINK_DOWN (reset state) and LINK_UP.
- LINK_DOWN:
  - `o_hex[3]` = 0, `o_cmd` = 0, watchdog held at 0.
  - A recognised byte (including `S` or `H`) moves to LINK_UP, sets the command per the table (`H` leaves it at 0), and clears the watchdog.
- LINK_UP:
  - `o_hex[3]` = 1.
  - The watchdog increments every cycle in which no recognised byte arrives.
  - A recognised byte clears the watchdog to 0 and updates the command per the table.
  - When the watchdog equals `TIMEOUT_CYC-1` and no recognised byte arrives that cycle, the block moves to LINK_DOWN: command goes to 0, watchdog goes to 0, and `o_timeout` pulses.
  - The transition to LINK_DOWN also pulses `o_cmd_strobe` if the command was non-zero.
- `o_cmd_strobe` pulses exactly when the registered command value differs from its previous value. A repeated identical command gives no pulse.

Boundary rules:
- A recognised byte in the same cycle as watchdog expiry: the byte wins. The link stays up, the watchdog clears, and `o_timeout` does not pulse.
- An unrecognised byte in the expiry cycle does not prevent the timeout. `o_err` and `o_timeout` pulse together.
- `i_rx_valid` is sampled every cycle. Back-to-back valid bytes are each processed, and the last one determines the command.
- `i_rst` mid-operation overrides all other inputs in that cycle.

## Timing

- All outputs are registered.
- Reset values: `o_hex` = 0, `o_cmd` = 0, `o_cmd_strobe` = 0, `o_err` = 0, `o_err_cnt` = 0, `o_timeout` = 0. State is LINK_DOWN and the watchdog is 0.
- Latency: a byte accepted at edge N appears on `o_hex`, `o_cmd`, `o_cmd_strobe` and `o_err` after edge N (visible in cycle N+1).
- Timeout: the last recognised byte is accepted at edge N. The link drops at edge N+`TIMEOUT_CYC`, and `o_timeout` is high for that single cycle.
- Pulses last exactly one cycle. There is no handshake back-pressure; every strobed byte is consumed.

## Test plan

Run with `TIMEOUT_CYC`=20.
- Reset, then idle for 50 cycles → `o_hex`=0000 throughout; no pulses.
- Byte 0x46 (`F`) → next cycle `o_hex`=1010 and `o_cmd_strobe`=1. Then `f` → no strobe, `o_hex` unchanged. Then `L` → `o_hex`=1101 with a strobe.
- `R`, then no bytes → at exactly 20 cycles after acceptance, `o_hex`=0000 and `o_timeout` and `o_cmd_strobe` pulse once. Repeat `H` every 15 cycles for 200 cycles → link stays up and `o_cmd` stays 3.
- Send `Q`, `7` and 0xFF → 3 `o_err` pulses, `o_err_cnt`=3, `o_hex` unchanged. Send 300 bad bytes → `o_err_cnt` saturates at 255.
- `B` at edge N, then `D` at edge N+20 (the expiry cycle) → no timeout, and `o_hex`=1110. Separately, `Z` in the expiry cycle → `o_err` and `o_timeout` pulse in the same cycle and the link drops.
- `T`, then assert `i_rst` for 1 cycle together with `i_rx_valid` carrying `B` → all outputs 0 next cycle and state LINK_DOWN.
